// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared widths and types for the TDC thermometer-to-binary path
package tdc_pkg;

  localparam int N_BITS  = 5;
  localparam int THERM_W = 2**N_BITS - 1;

  typedef logic [THERM_W-1:0] therm_t;
  typedef logic [N_BITS-1:0]  bin_t;

endpackage

// File: rtl/therm_bubble_fix.sv
// rtl/therm_bubble_fix.sv - 3-tap majority bubble suppression and non-monotonic flag
module therm_bubble_fix
  import tdc_pkg::*;
(
  input  therm_t therm_i,
  output therm_t fixed_o,
  output logic   bubble_o
);

  // Padded so the first tap sees a virtual 1 below it and the last a virtual 0 above it.
  logic [THERM_W+1:0] ext;

  assign ext = {1'b0, therm_i, 1'b1};

  always_comb begin
    fixed_o = '0;
    for (int i = 0; i < THERM_W; i++) begin
      fixed_o[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
  end

  always_comb begin
    bubble_o = 1'b0;
    for (int i = 1; i < THERM_W; i++) begin
      bubble_o = bubble_o | (therm_i[i] & ~therm_i[i-1]);
    end
  end

endmodule

// File: rtl/tdc_therm2bin.sv
// rtl/tdc_therm2bin.sv - 3-stage thermometer-to-binary encoder with bubble count
module tdc_therm2bin
  import tdc_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  therm_t               in_therm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output bin_t                 out_bin,
  output logic                 out_bubble,
  input  logic                 cnt_clr,
  output logic [ERR_CNT_W-1:0] bubble_cnt
);

  logic   stall;
  logic   s1_valid_q;
  therm_t s1_therm_q;
  logic   s2_valid_q;
  therm_t s2_therm_q;
  logic   s2_bubble_q;
  logic   s3_valid_q;
  bin_t   s3_bin_q;
  logic   s3_bubble_q;
  therm_t fixed;
  logic   bubble;
  bin_t   bin_d;
  logic [ERR_CNT_W-1:0] cnt_q;
  logic [ERR_CNT_W-1:0] cnt_d;

  // A single global stall freezes every stage, so no skid buffering is needed.
  assign stall    = s3_valid_q & ~out_ready;
  assign in_ready = ~stall;

  therm_bubble_fix u_fix (
    .therm_i  (s1_therm_q),
    .fixed_o  (fixed),
    .bubble_o (bubble)
  );

  always_comb begin
    bin_d = '0;
    for (int i = 0; i < THERM_W; i++) begin
      bin_d = bin_d + bin_t'(s2_therm_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_therm_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_therm_q  <= '0;
      s2_bubble_q <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_bin_q    <= '0;
      s3_bubble_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q  <= in_valid;
      s1_therm_q  <= in_therm;
      s2_valid_q  <= s1_valid_q;
      s2_therm_q  <= fixed;
      s2_bubble_q <= bubble;
      s3_valid_q  <= s2_valid_q;
      s3_bin_q    <= bin_d;
      s3_bubble_q <= s2_bubble_q;
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (s3_valid_q && out_ready && s3_bubble_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = s3_valid_q;
  assign out_bin    = s3_bin_q;
  assign out_bubble = s3_bubble_q;
  assign bubble_cnt = cnt_q;

endmodule
